fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and sequencing stage that sits directly upstream of the control decoder. It owns the program counter that addresses the instruction ROM, and it consumes the decoder's branch enable together with the ALU branch condition. It also starts and halts program execution on a level handshake, and counts retired instructions for the test harness.

## Interface
- PC_W, 10, program counter / instruction ROM address width
- START_ADDR, 0, address loaded on program start and on reset
- CNT_W, 16, width of retired-instruction counter
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  level request to (re)start the program; honoured only in IDLE or DONE
- Stall  in  1  hold current instruction this cycle (multi-cycle memory access)
- BranchEn  in  1  decoder says the current instruction is a branch
- Taken  in  1  ALU branch condition for the current instruction
- Target  in  PC_W  absolute branch target from branch lookup
- HaltReq  in  1  decoder says the current instruction is the halt encoding
- ProgCtr  out  PC_W  registered address of the current instruction
- Running  out  1  registered; 1 while in RUN
- Done  out  1  registered; 1 while in DONE
- InstCnt  out  CNT_W  registered count of retired instructions in the current run

## Operation
- States: IDLE, RUN, DONE, held in a registered FSM.
- Reset (Reset=0, asynchronous and immediate):
  - state=IDLE, ProgCtr=START_ADDR, InstCnt=0, Running=0, Done=0.
  - This applies mid-run as well; the cycle in flight is discarded.
- IDLE:
  - ProgCtr and InstCnt hold.
  - Start=1 → RUN, with ProgCtr=START_ADDR and InstCnt=0.
- RUN, per-cycle priority Stall > HaltReq > taken branch > increment:
  - Stall=1: ProgCtr and InstCnt hold. BranchEn, Taken and HaltReq are ignored this cycle.
  - HaltReq=1: → DONE. ProgCtr holds at the halt address. InstCnt+1.
  - BranchEn=1 and Taken=1: ProgCtr=Target. InstCnt+1.
  - Otherwise: ProgCtr=ProgCtr+1, modulo 2^PC_W. InstCnt+1.
  - BranchEn=1 with Taken=0 is a plain increment.
  - Start is ignored in RUN.
- DONE:
  - ProgCtr and InstCnt hold, so the harness can read the final count.
  - Start=1 → RUN, with ProgCtr=START_ADDR and InstCnt=0.
- Arithmetic and width rules:
  - PC increment wraps from all-ones to 0 with no flag.
  - InstCnt saturates at 2^CNT_W−1 and does not wrap.
  - Target is used unmodified; there is no relative offset.
- Running and Done are decoded from the state register only, never from inputs. They are mutually exclusive, and both are 0 in IDLE.

## Timing
- Instruction ROM and decoder are combinational from ProgCtr. BranchEn, Taken, Target and HaltReq therefore refer to the instruction at the current ProgCtr and are sampled on the same rising edge.
- Branch latency is zero: the instruction at Target is current in the cycle after the branch. There is no delay slot and no flush.
- Start sampled in IDLE/DONE at edge N gives Running=1 and ProgCtr=START_ADDR from edge N onward. The first instruction executes in the cycle after edge N.
- HaltReq at edge N gives Done=1 from edge N onward. The halt instruction counts as retired.
- Simultaneous HaltReq and BranchEn/Taken: halt wins and ProgCtr holds.
- Simultaneous Stall and HaltReq: stall wins and the FSM stays in RUN.
- Start held high continuously restarts the program immediately after each DONE. The harness drops Start after Running is seen.
- Reset deassertion is synchronised externally. The first active edge after release sees IDLE.

## Test plan
- Reset then Start=1 for one cycle, no branches, HaltReq at address 5:
  - ProgCtr steps 0,1,2,3,4,5.
  - Done=1 the cycle after 5; ProgCtr stays 5.
  - InstCnt=6.
- BranchEn=1, Taken=1, Target=0x040 at ProgCtr=2:
  - Next ProgCtr=0x040, then 0x041.
  - With Taken=0 instead, next ProgCtr=3.
- Stall=1 for 3 cycles at ProgCtr=7 with HaltReq=1 and BranchEn=1 asserted:
  - ProgCtr holds 7, InstCnt holds, state stays RUN.
  - After Stall drops, the FSM halts.
- PC_W=10, run from ProgCtr=0x3FF with no branch:
  - Next ProgCtr=0x000 and Running stays 1.
- Force InstCnt to 0xFFFE, then run 3 more instructions:
  - InstCnt reads 0xFFFF and stays.
- Reset=0 asserted asynchronously mid-RUN at ProgCtr=0x12:
  - ProgCtr=START_ADDR, InstCnt=0, Running=0 immediately, before the next edge.
  - Start from DONE: ProgCtr returns to 0 and InstCnt clears.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: program counter and run/halt sequencer.
// Owns the instruction ROM address. It applies zero-latency absolute branches,
// starts and halts the program on a level handshake, and counts retired
// instructions for the harness.
module fetch_unit #(
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              taken,
  input  logic [PC_W-1:0]   target,
  input  logic              halt_req,
  output logic [PC_W-1:0]   prog_ctr,
  output logic              running,
  output logic              done,
  output logic [CNT_W-1:0]  inst_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [PC_W-1:0]  PC_START = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       state_reg, state_next;
  logic [PC_W-1:0]  prog_ctr_reg, prog_ctr_next;
  logic [CNT_W-1:0] inst_cnt_reg, inst_cnt_next;
  logic [PC_W-1:0]  pc_inc;
  logic [CNT_W-1:0] cnt_inc;

  // Sequential PC wraps naturally at the address width. The retired count
  // sticks at all-ones so a long run never reports a small value.
  always_comb begin
    pc_inc  = prog_ctr_reg + PC_ONE;
    cnt_inc = (inst_cnt_reg == CNT_MAX) ? inst_cnt_reg : (inst_cnt_reg + CNT_ONE);
  end

  // Next-state logic. In RUN the priority is stall, then halt, then taken
  // branch, then increment.
  always_comb begin
    state_next    = state_reg;
    prog_ctr_next = prog_ctr_reg;
    inst_cnt_next = inst_cnt_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next    = RUN;
          prog_ctr_next = PC_START;
          inst_cnt_next = '0;
        end
      end
      RUN: begin
        if (stall) begin
          // Hold everything. Decoder outputs belong to an instruction that
          // has not finished yet.
          state_next = RUN;
        end else if (halt_req) begin
          // The halt instruction retires, and the PC stays on it.
          state_next    = DONE;
          inst_cnt_next = cnt_inc;
        end else if (branch_en && taken) begin
          prog_ctr_next = target;
          inst_cnt_next = cnt_inc;
        end else begin
          prog_ctr_next = pc_inc;
          inst_cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next    = IDLE;
        prog_ctr_next = PC_START;
        inst_cnt_next = '0;
      end
    endcase
  end

  // State, PC and counter registers. Reset drops any cycle in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      prog_ctr_reg <= PC_START;
      inst_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      prog_ctr_reg <= prog_ctr_next;
      inst_cnt_reg <= inst_cnt_next;
    end
  end

  // Status flags are decoded from the state register only. They are
  // glitch-free and never depend on the inputs.
  always_comb begin
    running = (state_reg == RUN);
    done    = (state_reg == DONE);
  end

  assign prog_ctr = prog_ctr_reg;
  assign inst_cnt = inst_cnt_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random checks of fetch_unit against a
// behavioural model of the run/halt/branch rules.
module tb_fetch_unit;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stall, branch_en, taken, halt_req;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  prog_ctr;
  logic             running, done;
  logic [CNT_W-1:0] inst_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0=idle, 1=run, 2=done.
  int m_mode, m_pc, m_cnt;

  fetch_unit #(.PC_W(PC_W), .START_ADDR(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_en(branch_en), .taken(taken), .target(target),
    .halt_req(halt_req), .prog_ctr(prog_ctr), .running(running),
    .done(done), .inst_cnt(inst_cnt)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0; m_pc = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge();
    if (m_mode != 1) begin
      if (start) begin m_mode = 1; m_pc = 0; m_cnt = 0; end
    end else if (!stall) begin
      m_cnt = (m_cnt + 1 > CNT_TOP) ? CNT_TOP : m_cnt + 1;
      if (halt_req)                m_mode = 2;
      else if (branch_en && taken) m_pc = int'(target);
      else                         m_pc = (m_pc + 1) % PC_MOD;
    end
  endfunction

  task automatic check(input string tag);
    checks++;
    assert (int'(prog_ctr) === m_pc) else begin
      errors++;
      $error("FAIL %s prog_ctr got %0h expected %0h", tag, prog_ctr, m_pc);
    end
    checks++;
    assert (int'(inst_cnt) === m_cnt) else begin
      errors++;
      $error("FAIL %s inst_cnt got %0h expected %0h", tag, inst_cnt, m_cnt);
    end
    checks++;
    assert ({running, done} === {m_mode == 1, m_mode == 2}) else begin
      errors++;
      $error("FAIL %s running/done got %b%b expected %b%b", tag, running, done,
             m_mode == 1, m_mode == 2);
    end
  endtask

  // One clock edge: the model consumes the same inputs, then the outputs are
  // sampled 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    $display("step %-10s pc=%03h cnt=%04h run=%b done=%b", tag, prog_ctr, inst_cnt, running, done);
    check(tag);
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; branch_en = 0; taken = 0; halt_req = 0; target = '0;
  endtask

  task automatic do_start(input string tag);
    start = 1; step(tag); start = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    #12;
    check("reset");
    @(negedge clk); rst_n = 1;
    step("idle");

    // Straight-line program that halts at address 5.
    do_start("start1");
    for (int i = 0; i < 8; i++) begin
      halt_req = (m_pc == 5);
      step("seq");
    end
    halt_req = 0;
    checks++;
    assert (inst_cnt === 16'd6 && prog_ctr === 10'd5 && done === 1'b1) else begin
      errors++;
      $error("FAIL halt5 cnt=%0d pc=%0h done=%b expected 6/5/1", inst_cnt, prog_ctr, done);
    end

    // Taken branch at 2 goes to 0x40 and then 0x41.
    do_start("start2");
    for (int i = 0; i < 5; i++) begin
      branch_en = (m_pc == 2); taken = 1; target = 10'h040;
      halt_req = (m_pc == 10'h041);
      step("br_taken");
    end
    idle_inputs();
    checks++;
    assert (prog_ctr === 10'h041) else begin
      errors++;
      $error("FAIL br_final pc got %0h expected 041", prog_ctr);
    end

    // Not-taken branch at 2 falls through to 3.
    do_start("start3");
    for (int i = 0; i < 4; i++) begin
      branch_en = (m_pc == 2); taken = 0; target = 10'h040;
      halt_req = (m_pc == 3);
      step("br_ntaken");
    end
    idle_inputs();

    // A stall at 7 masks halt and branch for 3 cycles, then the halt goes through.
    do_start("start4");
    while (m_pc != 7) step("to7");
    stall = 1; halt_req = 1; branch_en = 1; taken = 1; target = 10'h100;
    for (int i = 0; i < 3; i++) step("stall");
    stall = 0;
    step("unstall");
    idle_inputs();

    // PC wraps from 0x3FF to 0.
    do_start("start5");
    branch_en = 1; taken = 1; target = 10'h3FF;
    step("to3ff");
    idle_inputs();
    step("wrap");
    step("wrap2");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      branch_en = $urandom_range(0, 1);
      taken     = $urandom_range(0, 1);
      target    = PC_W'($urandom);
      halt_req  = ($urandom_range(0, 24) == 0);
      step("random");
    end
    idle_inputs();

    // Counter saturation: a long run without halt.
    halt_req = 1; step("pre_sat");
    halt_req = 0;
    do_start("start6");
    for (int i = 0; i < CNT_TOP + 3; i++) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    check("saturate");
    checks++;
    assert (inst_cnt === 16'hFFFF) else begin
      errors++;
      $error("FAIL sat_value got %0h expected ffff", inst_cnt);
    end

    // Asynchronous reset while running at 0x12.
    halt_req = 1; step("halt_sat");
    halt_req = 0;
    do_start("start7");
    branch_en = 1; taken = 1; target = 10'h012;
    step("to12");
    idle_inputs();
    #2 rst_n = 0;
    model_reset();
    #1 check("async_rst");
    @(negedge clk); rst_n = 1;
    step("post_rst");
    do_start("start8");
    step("run_again");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
